fnd_bcd_digit_driver: RTL and testbench

- Downstream consumer of the 4-digit FND ring-counter select (active-low one-hot o_fnd_sel).
- Accepts a binary value on a load pulse and converts it to 4 BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Holds the result in a display register.
- Drives the active-low 7-segment font and common-anode enables for whichever digit the ring counter currently selects.

---
 rtl/fnd_bcd_digit_driver.sv | 150 +++++++++++++++
 tb/tb_fnd_bcd_digit_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_bcd_digit_driver.sv
// Binary-to-BCD FND digit driver: a double-dabble FSM feeds a display register
// that is muxed onto the active-low 7-segment outputs. Optional: FND_LZ_BLANK_EN.
module fnd_bcd_digit_driver #(
  parameter int DATA_W  = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_load,
  input  logic [3:0]        i_fnd_sel,
  output logic [3:0]        o_fnd_com,
  output logic [7:0]        o_fnd_font,
  output logic              o_busy,
  output logic              o_done
);

  localparam int          CNT_W   = $clog2(DATA_W + 1);
  localparam logic [31:0] MAX_VEC = 32'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] bin_q;
  logic [15:0]       bcd_q;
  logic [15:0]       disp_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] load_val;
  logic [15:0]       bcd_adj;
  logic              last_iter;
  logic [7:0]        digit_font;
  logic              blank_tens;
  logic              blank_hund;
  logic              blank_thou;

  function automatic logic [7:0] seg_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Clamp on the full unsigned input before it enters the shifter.
  assign load_val  = ({{(32-DATA_W){1'b0}}, i_value} > MAX_VEC) ? MAX_VEC[DATA_W-1:0] : i_value;
  assign last_iter = (cnt_q == CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load) state_nxt = CONV;
      CONV:    if (last_iter) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state == CONV);
  assign o_done = (state == LATCH);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            bin_q <= load_val;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
          end
        end
        CONV: begin
          bcd_q <= {bcd_adj[14:0], bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
        end
        LATCH:   disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

`ifdef FND_LZ_BLANK_EN
  // A digit blanks only when it and every digit above it are zero.
  assign blank_thou = (disp_q[15:12] == 4'd0);
  assign blank_hund = (disp_q[15:8] == 8'd0);
  assign blank_tens = (disp_q[15:4] == 12'd0);
`else
  assign blank_thou = 1'b0;
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    digit_font = 8'hFF;
    case (i_fnd_sel)
      4'b1110: digit_font = seg_font(disp_q[3:0]);
      4'b1101: digit_font = blank_tens ? 8'hFF : seg_font(disp_q[7:4]);
      4'b1011: digit_font = blank_hund ? 8'hFF : seg_font(disp_q[11:8]);
      4'b0111: digit_font = blank_thou ? 8'hFF : seg_font(disp_q[15:12]);
      default: digit_font = 8'hFF;
    endcase
  end

  // Common and font are registered together so they always name the same digit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fnd_com  <= 4'b1111;
      o_fnd_font <= 8'hFF;
    end else begin
      o_fnd_com  <= i_fnd_sel;
      o_fnd_font <= digit_font;
    end
  end

endmodule

// File: tb/tb_fnd_bcd_digit_driver.sv
// Self-checking bench for fnd_bcd_digit_driver against a decimal-arithmetic model.
module tb_fnd_bcd_digit_driver;

  localparam int DATA_W  = 14;
  localparam int MAX_VAL = 9999;

  localparam logic [7:0] FONT    [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [3:0] ONE_HOT [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [DATA_W-1:0] i_value;
  logic              i_load;
  logic [3:0]        i_fnd_sel;
  logic [3:0]        o_fnd_com;
  logic [7:0]        o_fnd_font;
  logic              o_busy;
  logic              o_done;

  int n_cmp;
  int n_bad;
  int shown;

  fnd_bcd_digit_driver #(.DATA_W(DATA_W), .MAX_VAL(MAX_VAL)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_fnd_sel  (i_fnd_sel),
    .o_fnd_com  (o_fnd_com),
    .o_fnd_font (o_fnd_font),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic [7:0] exp_font(input int val, input logic [3:0] sel);
    int k;
    int p;
    case (sel)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: return 8'hFF;
    endcase
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
`ifdef FND_LZ_BLANK_EN
    if (k > 0 && val < p) return 8'hFF;
`endif
    return FONT[(val / p) % 10];
  endfunction

  task automatic read_digit(input logic [3:0] sel, input string tag);
    @(negedge i_clk);
    i_fnd_sel = sel;
    @(negedge i_clk);
    check({tag, "_font"}, 32'(o_fnd_font), 32'(exp_font(shown, sel)));
    check({tag, "_com"}, 32'(o_fnd_com), 32'(sel));
  endtask

  task automatic read_all(input string tag);
    for (int d = 0; d < 4; d++) read_digit(ONE_HOT[d], tag);
  endtask

  // extra_at: edge offset (from the load edge) at which a second, ignored load is sampled.
  task automatic convert(input int v, input int extra_at, input int extra_v, input string tag);
    int         old_val;
    int         dones;
    logic [3:0] sel;
    old_val = shown;
    dones   = 0;
    sel     = ONE_HOT[$urandom_range(0, 3)];
    @(negedge i_clk);
    i_value   = DATA_W'(v);
    i_load    = 1'b1;
    i_fnd_sel = sel;
    @(negedge i_clk);
    i_load = 1'b0;
    for (int j = 0; j <= DATA_W + 2; j++) begin
      check({tag, "_busy"}, 32'(o_busy), 32'(j < DATA_W));
      check({tag, "_done"}, 32'(o_done), 32'(j == DATA_W));
      if (o_done) dones++;
      check({tag, "_hold"}, 32'(o_fnd_font),
            32'((j <= DATA_W + 1) ? exp_font(old_val, sel) : exp_font(clamp(v), sel)));
      if (j == extra_at - 1) begin
        i_value = DATA_W'(extra_v);
        i_load  = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      @(negedge i_clk);
    end
    i_load = 1'b0;
    shown  = clamp(v);
    check({tag, "_ndone"}, 32'(dones), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_font"}, 32'(o_fnd_font), 32'hFF);
    check({tag, "_com"}, 32'(o_fnd_com), 32'hF);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    logic [3:0] bad_sel;
    n_cmp     = 0;
    n_bad     = 0;
    shown     = 0;
    i_reset   = 1'b1;
    i_load    = 1'b0;
    i_value   = '0;
    i_fnd_sel = 4'b1111;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("por");
    i_reset   = 1'b0;
    i_fnd_sel = 4'b1110;
    @(negedge i_clk);
    check("por_ones", 32'(o_fnd_font), 32'hC0);

    convert(1234, -1, 0, "c1234");
    read_all("d1234");
    read_digit(4'b1110, "lit1234");
    check("lit1234_ones", 32'(o_fnd_font), 32'h99);

    convert(16383, -1, 0, "clamp");
    read_all("d9999");
    convert(10000, -1, 0, "clamp10k");
    read_all("d10k");

    convert(1234, 5, 5678, "ign_busy");
    read_all("dign");
    convert(7, DATA_W + 1, 4321, "ign_latch");
    read_all("d0007");
    convert(0, -1, 0, "zero");
    read_all("d0000");
    convert(10, -1, 0, "ten");
    read_all("d0010");

    for (int n = 0; n < 16; n++) begin
      convert(int'($urandom_range(0, (1 << DATA_W) - 1)), -1, 0, "rnd");
      read_all("drnd");
    end

    read_digit(4'b1111, "sel1111");
    read_digit(4'b1100, "sel1100");
    read_digit(4'b0000, "sel0000");
    for (int n = 0; n < 6; n++) begin
      do bad_sel = 4'($urandom_range(0, 15));
      while (bad_sel == 4'b1110 || bad_sel == 4'b1101 || bad_sel == 4'b1011 || bad_sel == 4'b0111);
      read_digit(bad_sel, "selbad");
    end

    // Abort a conversion with reset between edges N+6 and N+7.
    convert(4321, -1, 0, "pre_rst");
    @(negedge i_clk);
    i_value = DATA_W'(8765);
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load = 1'b0;
    repeat (6) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge i_clk);
    i_reset = 1'b0;
    shown   = 0;
    for (int j = 0; j < DATA_W + 4; j++) begin
      check("postrst_done", 32'(o_done), 32'd0);
      check("postrst_busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
    end
    read_all("drst");

    convert(7, -1, 0, "c7b");
    read_all("d7b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
